// File: rtl/dot_product_sequencer.sv
// Feeds stored weight/activation vectors into the mac block one pair per cycle
// and offers the captured accumulator to the next stage through valid/ready.
module dot_product_sequencer #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_weight,
    input  logic [DW-1:0] wr_act,
    input  logic          start,
    output logic          busy,
    output logic          mac_clr,
    output logic          mac_enable,
    output logic [DW-1:0] mac_a,
    output logic [DW-1:0] mac_b,
    input  logic [DW-1:0] mac_out,
    output logic [DW-1:0] result,
    output logic          result_valid,
    input  logic          result_ready
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
    localparam logic [AW:0]   N_LIM    = (AW + 1)'(N);

    logic [2:0]    state;
    logic [AW-1:0] idx;
    logic [AW-1:0] idx_nxt;
    logic [DW-1:0] weight [N];
    logic [DW-1:0] act    [N];
    logic          wr_ok;

    assign idx_nxt = idx + 1'b1;
    assign wr_ok   = wr_en && (state == S_IDLE) && ({1'b0, wr_addr} < N_LIM);

    assign busy         = (state == S_CLEAR) || (state == S_RUN) || (state == S_DRAIN);
    assign mac_clr      = (state == S_CLEAR);
    assign result_valid = (state == S_HOLD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < N; i++) begin
                weight[i] <= '0;
                act[i]    <= '0;
            end
        end else if (wr_ok) begin
            weight[wr_addr] <= wr_weight;
            act[wr_addr]    <= wr_act;
        end
    end

    // Operands are loaded one edge ahead so each RUN cycle presents element idx.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            idx        <= '0;
            mac_enable <= 1'b0;
            mac_a      <= '0;
            mac_b      <= '0;
            result     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !result_valid) begin
                        state <= S_CLEAR;
                        idx   <= '0;
                    end
                end
                S_CLEAR: begin
                    state      <= S_RUN;
                    idx        <= '0;
                    mac_enable <= 1'b1;
                    mac_a      <= weight[0];
                    mac_b      <= act[0];
                end
                S_RUN: begin
                    if (idx == LAST_IDX) begin
                        state      <= S_DRAIN;
                        mac_enable <= 1'b0;
                        mac_a      <= '0;
                        mac_b      <= '0;
                    end else begin
                        idx   <= idx_nxt;
                        mac_a <= weight[idx_nxt];
                        mac_b <= act[idx_nxt];
                    end
                end
                S_DRAIN: begin
                    result <= mac_out;
                    state  <= S_HOLD;
                end
                S_HOLD: begin
                    if (result_ready) state <= S_IDLE;
                end
                default: begin
                    state      <= S_IDLE;
                    mac_enable <= 1'b0;
                    mac_a      <= '0;
                    mac_b      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Bench for dot_product_sequencer: three instances (N=4, N=1, N=3) sharing stimulus,
// each feeding a behavioural Q1.7 MAC; results checked against a vector-level model.
module tb_dot_product_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic       start = 1'b0;
    logic       result_ready = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [7:0] wr_weight = '0;
    logic [7:0] wr_act = '0;

    logic       busy_o [3];
    logic       clr_o  [3];
    logic       en_o   [3];
    logic       rv_o   [3];
    logic [7:0] a_o    [3];
    logic [7:0] b_o    [3];
    logic [7:0] res_o  [3];
    logic [7:0] acc    [3];

    int checks = 0;
    int errors = 0;
    int n_of    [3] = '{4, 1, 3};
    int mask_of [3] = '{3, 1, 3};
    logic [7:0] ref_w [3][16];
    logic [7:0] ref_x [3][16];

    logic [7:0] obs_a [$];
    logic [7:0] obs_b [$];
    int         obs_k [$];
    int         clr_cnt;
    int         lat;

    always #5 clk = ~clk;

    dot_product_sequencer #(.N(4), .DW(8), .AW(2)) u0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_weight(wr_weight), .wr_act(wr_act), .start(start),
        .busy(busy_o[0]), .mac_clr(clr_o[0]), .mac_enable(en_o[0]),
        .mac_a(a_o[0]), .mac_b(b_o[0]), .mac_out(acc[0]),
        .result(res_o[0]), .result_valid(rv_o[0]), .result_ready(result_ready)
    );

    dot_product_sequencer #(.N(1), .DW(8), .AW(1)) u1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr[0:0]),
        .wr_weight(wr_weight), .wr_act(wr_act), .start(start),
        .busy(busy_o[1]), .mac_clr(clr_o[1]), .mac_enable(en_o[1]),
        .mac_a(a_o[1]), .mac_b(b_o[1]), .mac_out(acc[1]),
        .result(res_o[1]), .result_valid(rv_o[1]), .result_ready(result_ready)
    );

    dot_product_sequencer #(.N(3), .DW(8), .AW(2)) u2 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_weight(wr_weight), .wr_act(wr_act), .start(start),
        .busy(busy_o[2]), .mac_clr(clr_o[2]), .mac_enable(en_o[2]),
        .mac_a(a_o[2]), .mac_b(b_o[2]), .mac_out(acc[2]),
        .result(res_o[2]), .result_valid(rv_o[2]), .result_ready(result_ready)
    );

    // Q1.7 x Q1.7 product rescaled to Q1.7, wrapping.
    function automatic logic [7:0] q17(input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] p;
        p = $signed(a) * $signed(b);
        return p[14:7];
    endfunction

    // Stand-in for the downstream mac block.
    always @(posedge clk or negedge reset) begin
        for (int k = 0; k < 3; k++) begin
            if (!reset)        acc[k] <= '0;
            else if (clr_o[k]) acc[k] <= '0;
            else if (en_o[k])  acc[k] <= acc[k] + q17(a_o[k], b_o[k]);
        end
    end

    function automatic logic [7:0] exp_dot(input int inst);
        logic [7:0] s;
        s = '0;
        for (int i = 0; i < n_of[inst]; i++) s = s + q17(ref_w[inst][i], ref_x[inst][i]);
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ref();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 16; i++) begin
                ref_w[k][i] = '0;
                ref_x[k][i] = '0;
            end
    endtask

    task automatic wr(input int addr, input logic [7:0] w, input logic [7:0] x);
        wr_en = 1'b1; wr_addr = addr[1:0]; wr_weight = w; wr_act = x;
        step();
        wr_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            int ea;
            ea = addr & mask_of[k];
            if (ea < n_of[k]) begin
                ref_w[k][ea] = w;
                ref_x[k][ea] = x;
            end
        end
    endtask

    // Pulses start and records what instance inst shows until result_valid rises.
    task automatic run_dp(input int inst, input bit poke_busy);
        obs_a.delete(); obs_b.delete(); obs_k.delete();
        clr_cnt = 0;
        lat = -1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (clr_o[inst]) clr_cnt++;
            if (en_o[inst]) begin
                obs_a.push_back(a_o[inst]);
                obs_b.push_back(b_o[inst]);
                obs_k.push_back(k);
            end
            if (rv_o[inst]) begin
                lat = k;
                break;
            end
            start = poke_busy && (k <= n_of[inst] + 1);
            step();
        end
        start = 1'b0;
    endtask

    task automatic accept_all();
        for (int k = 0; k < 60 && (busy_o[0] || busy_o[1] || busy_o[2]); k++) step();
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
    endtask

    task automatic test_dot(input string name, input int inst);
        int n;
        n = n_of[inst];
        run_dp(inst, 1'b0);
        checks++;
        if (clr_cnt !== 1) begin
            errors++; $display("FAIL %s mac_clr cycles: got %0d want 1", name, clr_cnt);
        end
        checks++;
        if (obs_a.size() != n) begin
            errors++; $display("FAIL %s enabled cycles: got %0d want %0d", name, obs_a.size(), n);
        end
        for (int i = 0; i < n && i < obs_a.size(); i++) begin
            checks++;
            if (obs_a[i] !== ref_w[inst][i] || obs_b[i] !== ref_x[inst][i] || obs_k[i] !== i + 1) begin
                errors++;
                $display("FAIL %s elem%0d: got a=%h b=%h at cycle %0d want a=%h b=%h at cycle %0d",
                         name, i, obs_a[i], obs_b[i], obs_k[i], ref_w[inst][i], ref_x[inst][i], i + 1);
            end
        end
        checks++;
        if (lat !== n + 2) begin
            errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, n + 2);
        end
        checks++;
        if (res_o[inst] !== exp_dot(inst)) begin
            errors++; $display("FAIL %s result: got %h want %h", name, res_o[inst], exp_dot(inst));
        end
        accept_all();
        checks++;
        if (rv_o[inst] !== 1'b0) begin
            errors++; $display("FAIL %s valid after accept: got %b want 0", name, rv_o[inst]);
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({busy_o[k], clr_o[k], en_o[k], rv_o[k], a_o[k], b_o[k], res_o[k]} !== '0) begin
                errors++;
                $display("FAIL reset inst%0d: got busy=%b clr=%b en=%b rv=%b a=%h b=%h res=%h want all 0",
                         k, busy_o[k], clr_o[k], en_o[k], rv_o[k], a_o[k], b_o[k], res_o[k]);
            end
        end
        @(negedge clk) reset = 1'b1;
        step();
    endtask

    task automatic test_normal();
        wr(0, 8'h71, 8'h51); wr(1, 8'h04, 8'h0A); wr(2, 8'h0C, 8'h02); wr(3, 8'h02, 8'h03);
        test_dot("normal", 0);
    endtask

    task automatic test_signed();
        wr(0, 8'h01, 8'hFF); wr(1, 8'hFF, 8'h01); wr(2, 8'hFF, 8'hFE); wr(3, 8'hEC, 8'h02);
        test_dot("signed", 0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++) wr(i, 8'($urandom), 8'($urandom));
            test_dot((r == 3) ? "rand_n3" : "rand", (r == 3) ? 2 : 0);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) wr(i, 8'($urandom_range(1, 127)), 8'($urandom_range(1, 127)));
        run_dp(0, 1'b0);
        checks++;
        if (lat !== 6) begin
            errors++; $display("FAIL bp latency: got %0d want 6", lat);
        end
        for (int c = 0; c < 10; c++) begin
            start = (c == 2);
            wr_en = (c == 4); wr_addr = 2'd0; wr_weight = 8'h7F; wr_act = 8'h7F;
            step();
            start = 1'b0; wr_en = 1'b0;
            checks++;
            if (rv_o[0] !== 1'b1 || res_o[0] !== exp_dot(0) || clr_o[0] !== 1'b0 || busy_o[0] !== 1'b0) begin
                errors++;
                $display("FAIL bp hold c%0d: got rv=%b res=%h clr=%b busy=%b want rv=1 res=%h clr=0 busy=0",
                         c, rv_o[0], res_o[0], clr_o[0], busy_o[0], exp_dot(0));
            end
        end
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        checks++;
        if (rv_o[0] !== 1'b0) begin
            errors++; $display("FAIL bp release: got rv=%b want 0", rv_o[0]);
        end
        test_dot("bp_after", 0);
    endtask

    task automatic test_busy_reject();
        for (int i = 0; i < 4; i++) wr(i, 8'($urandom), 8'($urandom));
        run_dp(0, 1'b1);
        checks++;
        if (clr_cnt !== 1 || obs_a.size() != 4 || lat !== 6 || res_o[0] !== exp_dot(0)) begin
            errors++;
            $display("FAIL busy_reject run: got clr=%0d en=%0d lat=%0d res=%h want 1 4 6 %h",
                     clr_cnt, obs_a.size(), lat, res_o[0], exp_dot(0));
        end
        accept_all();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (busy_o[0] !== 1'b0 || clr_o[0] !== 1'b0) begin
                errors++; $display("FAIL busy_reject idle c%0d: got busy=%b clr=%b want 0 0", c, busy_o[0], clr_o[0]);
            end
            step();
        end
    endtask

    task automatic test_reset_mid_run();
        wr(0, 8'h7F, 8'h7F); wr(1, 8'h11, 8'h22); wr(2, 8'h33, 8'h44); wr(3, 8'h55, 8'h66);
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        checks++;
        if (en_o[0] !== 1'b1 || a_o[0] !== 8'h33 || b_o[0] !== 8'h44) begin
            errors++; $display("FAIL rst_mid elem2: got en=%b a=%h b=%h want 1 33 44", en_o[0], a_o[0], b_o[0]);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({busy_o[0], clr_o[0], en_o[0], rv_o[0], a_o[0], b_o[0], res_o[0]} !== '0) begin
            errors++;
            $display("FAIL rst_mid outputs: got busy=%b clr=%b en=%b rv=%b a=%h b=%h res=%h want all 0",
                     busy_o[0], clr_o[0], en_o[0], rv_o[0], a_o[0], b_o[0], res_o[0]);
        end
        clear_ref();
        @(negedge clk) reset = 1'b1;
        step();
        test_dot("rst_cleared", 0);
    endtask

    task automatic test_n1();
        wr(0, 8'h40, 8'h40);
        test_dot("n1", 1);
        checks++;
        if (exp_dot(1) !== 8'h20) begin
            errors++; $display("FAIL n1 model: got %h want 20", exp_dot(1));
        end
    endtask

    task automatic test_oob();
        for (int i = 0; i < 3; i++) wr(i, 8'($urandom), 8'($urandom));
        wr(3, 8'h55, 8'h66);
        test_dot("oob_n3", 2);
    endtask

    initial begin
        clear_ref();
        test_reset();
        test_normal();
        test_signed();
        test_random();
        test_backpressure();
        test_busy_reject();
        test_reset_mid_run();
        test_n1();
        test_oob();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dot_product_sequencer.md
# dot_product_sequencer

Upstream feeder for the `mac` block. Holds one weight vector and one activation vector of signed Q1.7 bytes, loaded through a write port. On `start`, it clears the MAC and streams the element pairs into it, one pair per cycle. It then captures the MAC's final accumulator into a result register and offers the value through a valid/ready handshake to the next stage, which is an activation/output buffer.

## Interface
- `N`, default 4: vector length, 1..16.
- `DW`, default 8: element and result width. Elements are signed Q1.7 and must match the MAC operand width.
- `AW`, default 2: address width, ceil(log2 N). Minimum 1.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low. Clears everything while low.
- `wr_en`  in  1: write strobe for the vector store.
- `wr_addr`  in  AW: element index. Writes with `wr_addr` >= N are dropped.
- `wr_weight`  in  DW: weight element, signed.
- `wr_act`  in  DW: activation element, signed.
- `start`  in  1: single-cycle request to run one dot product.
- `busy`  out  1: high from the CLEAR state through the DRAIN state.
- `mac_clr`  out  1: drives the MAC reset port. Active-high, one cycle.
- `mac_enable`  out  1: drives the MAC enable port.
- `mac_a`  out  DW: drives MAC operand a, which carries the weight.
- `mac_b`  out  DW: drives MAC operand b, which carries the activation.
- `mac_out`  in  DW: MAC accumulator output, signed.
- `result`  out  DW: captured dot product, signed.
- `result_valid`  out  1: `result` is held and pending.
- `result_ready`  in  1: downstream accepts the result.

## Operation
- Storage: two N x DW register arrays. On `reset`, all entries are set to 0.
  - A write occurs on a clock edge with `wr_en`=1, only when the FSM is in IDLE.
  - Writes in any other state are ignored.
- FSM states: IDLE, CLEAR, RUN, DRAIN, HOLD.
  - IDLE -> CLEAR: on `start`=1, but only if `result_valid`=0. A `start` in any other state, or while a result is pending, is dropped. It is not queued.
  - CLEAR -> RUN: after 1 cycle. `mac_clr`=1 in CLEAR and 0 in every other state.
  - RUN: lasts N cycles, with index i = 0..N-1.
    - Outputs in RUN: `mac_enable`=1, `mac_a`=weight[i], `mac_b`=act[i].
    - At i = N-1, go to DRAIN.
  - DRAIN: 1 cycle with `mac_enable`=0. Capture `mac_out` into `result` at the end of this cycle, then go to HOLD.
  - HOLD: `result_valid`=1. Go to IDLE on the edge where `result_ready`=1.
- `mac_a`, `mac_b`, and `mac_enable` are registered. They are 0 in IDLE, CLEAR, DRAIN and HOLD, so the MAC never sees stale operands.
- Arithmetic: the sequencer performs no arithmetic on data. Q1.7 multiply, accumulate and overflow behaviour belong to the MAC. `result` is a bit-exact copy of `mac_out`.
- Index counter: width AW. It resets to 0 on entry to CLEAR and never wraps during RUN.
- N=1: RUN lasts exactly one cycle.
- Reset mid-operation: asynchronous return to IDLE. All outputs go to 0, the stored vectors are cleared, and any pending result is discarded.
- Reset values: `busy`=0, `mac_clr`=0, `mac_enable`=0, `mac_a`=0, `mac_b`=0, `result`=0, `result_valid`=0.

## Timing
- Let edge E0 be the edge that samples `start`=1 in IDLE.
- CLEAR is the cycle E0..E1: `mac_clr`=1 and `busy`=1.
- RUN element i occupies cycle E(1+i)..E(2+i). The MAC accumulates element i at edge E(2+i).
- DRAIN is the cycle E(N+1)..E(N+2). `result` is loaded at E(N+2).
- `result_valid` rises after E(N+2). Start-to-valid latency is N+2 cycles.
- Handshake:
  - `result` and `result_valid` are stable until accepted.
  - Transfer occurs on an edge with `result_valid`=1 and `result_ready`=1.
  - `result_valid` drops after that edge.
  - The earliest next accepted `start` is on the following edge.
- Simultaneous `start` and `result_ready` in HOLD: the result is consumed and the `start` is dropped.

## Test plan
- Normal run:
  - Stimulus: load w={0x71,0x04,0x0C,0x02} and x={0x51,0x0A,0x02,0x03}, then pulse `start`.
  - Required response: `mac_clr` is high for exactly 1 cycle; `mac_a`/`mac_b` show 0x71/0x51, 0x04/0x0A, 0x0C/0x02, 0x02/0x03 on 4 consecutive cycles with `mac_enable`=1; `result_valid` rises N+2=6 cycles after the start edge; `result` equals the real MAC's `mac_out` at DRAIN.
- Signed operands:
  - Stimulus: load w={0x01,0xFF,0xFF,0xEC} and x={0xFF,0x01,0xFE,0x02}.
  - Required response: operands are driven unmodified, including sign bits, and `result` matches the MAC.
- Backpressure:
  - Stimulus: hold `result_ready`=0 for 10 cycles, pulsing `start` and `wr_en` (addr 0, 0x7F) during HOLD.
  - Required response: `result` is stable, no new CLEAR occurs, weight[0] is unchanged, and `result_valid` drops 1 cycle after `result_ready`=1.
- Reset mid-RUN:
  - Stimulus: assert `reset` low at RUN element 2, asynchronously, away from any clock edge.
  - Required response: all outputs are 0 immediately; after release, `start` produces all-zero operands because the vectors were cleared.
- Boundary:
  - Stimulus: set N=1 and load w[0]=0x40, x[0]=0x40.
  - Required response: exactly one enabled cycle and `result_valid` after 3 cycles.
  - Also: a write with `wr_addr`=N (N=3, AW=2) leaves the store unchanged.
- Busy rejection:
  - Stimulus: `start` pulses during CLEAR, RUN and DRAIN.
  - Required response: exactly one dot product is produced.
